decomp_input_feeder: RTL and testbench

DECOMP_INPUT_FEEDER -- requirements
Module: decomp_input_feeder

---
 rtl/decomp_input_feeder.sv | 141 ++++++++++++++
 tb/tb_decomp_input_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_input_feeder.sv
// Packs compressed-stream bus words into decompressor-width chunks, queues them with
// per-line metadata, and hands one chunk to the decompressor per request.
//
// state     | meaning
// ST_IDLE   | between lines; the next accepted word starts a line and latches its comp flag
// ST_ACTIVE | inside a line; comp flag held, waiting for the i_last word
module decomp_input_feeder #(
   parameter int WIDTH_IN      = 32,
   parameter int WIDTH_DATA_IN = 128,
   parameter int DEPTH         = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [WIDTH_IN-1:0]      i_word,
   input  logic                     i_last,
   input  logic                     i_comp_flag,
   input  logic                     i_req,
   output logic [WIDTH_DATA_IN-1:0] o_data,
   output logic                     o_update,
   output logic                     o_comp_flag,
   output logic                     o_line_start,
   output logic                     o_overrun
);

   localparam int EW = WIDTH_DATA_IN + 2;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} line_state_t;

   line_state_t              state_q, state_d;
   logic [1:0]               pcnt_q;
   logic [WIDTH_DATA_IN-1:0] pack_q, pack_d;
   logic                     line_comp_q, first_chunk_q;
   logic [EW-1:0]            mem [DEPTH];
   logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]            count_q;
   logic                     pending_q;

   logic          accept, push, push_fifo, pop, empty;
   logic          serve, serve_pend, serve_req, bypass;
   logic          word_comp;
   logic [EW-1:0] push_entry, serve_entry;

   assign o_ready    = (count_q < CW'(DEPTH)) && i_reset;
   assign accept     = i_valid && o_ready;
   assign push       = accept && ((pcnt_q == 2'd3) || i_last);
   assign empty      = (count_q == '0);
   assign word_comp  = (state_q == ST_IDLE) ? i_comp_flag : line_comp_q;

   always_comb begin
      pack_d = pack_q;
      pack_d[pcnt_q*WIDTH_IN +: WIDTH_IN] = i_word;
   end

   assign push_entry = {first_chunk_q, word_comp, pack_d};

   // A request into an empty FIFO that coincides with a push is served straight from the packer.
   assign serve_pend  = pending_q && !empty;
   assign serve_req   = i_req && !pending_q && (!empty || push);
   assign serve       = serve_pend || serve_req;
   assign bypass      = serve_req && empty;
   assign pop         = serve && !empty;
   assign push_fifo   = push && !bypass;
   assign serve_entry = bypass ? push_entry : mem[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            ST_IDLE:   if (!i_last) state_d = ST_ACTIVE;
            ST_ACTIVE: if (i_last)  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q       <= ST_IDLE;
         pcnt_q        <= '0;
         pack_q        <= '0;
         line_comp_q   <= 1'b0;
         first_chunk_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (accept) begin
            line_comp_q <= word_comp;
            pcnt_q      <= push ? 2'd0 : pcnt_q + 2'd1;
            pack_q      <= push ? '0 : pack_d;
         end
         if (push) first_chunk_q <= i_last;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_fifo) mem[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_fifo) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)       rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         case ({push_fifo, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pending_q    <= 1'b0;
         o_overrun    <= 1'b0;
         o_update     <= 1'b0;
         o_data       <= '0;
         o_comp_flag  <= 1'b0;
         o_line_start <= 1'b0;
      end else begin
         o_update <= serve;
         if (i_req && pending_q) o_overrun <= 1'b1;
         if (serve_pend)
            pending_q <= 1'b0;
         else if (i_req && !pending_q && !serve_req)
            pending_q <= 1'b1;
         if (serve) begin
            o_line_start <= serve_entry[EW-1];
            o_comp_flag  <= serve_entry[EW-2];
            o_data       <= serve_entry[WIDTH_DATA_IN-1:0];
         end
      end
   end

endmodule

// File: tb/tb_decomp_input_feeder.sv
// Directed and randomized bench for decomp_input_feeder, compared against a queue-based
// reference model of lines, chunks and requests.
module tb_decomp_input_feeder;

   localparam int WI    = 32;
   localparam int WD    = 128;
   localparam int DEPTH = 2;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [WI-1:0] i_word = '0;
   logic          i_last = 1'b0;
   logic          i_comp_flag = 1'b0;
   logic          i_req = 1'b0;
   logic [WD-1:0] o_data;
   logic          o_update, o_comp_flag, o_line_start, o_overrun;

   decomp_input_feeder #(.WIDTH_IN(WI), .WIDTH_DATA_IN(WD), .DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_word(i_word), .i_last(i_last), .i_comp_flag(i_comp_flag), .i_req(i_req),
      .o_data(o_data), .o_update(o_update), .o_comp_flag(o_comp_flag),
      .o_line_start(o_line_start), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic          ls;
      logic          cf;
      logic [WD-1:0] d;
   } entry_t;

   entry_t        mq[$];
   logic [WI-1:0] wq[$];
   bit            m_in_line, m_line_comp, m_first, m_pending, m_overrun;
   logic [WD-1:0] exp_data;
   bit            exp_cf, exp_ls, exp_upd;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      wq.delete();
      m_in_line = 0; m_line_comp = 0; m_first = 1; m_pending = 0; m_overrun = 0;
      exp_data = '0; exp_cf = 0; exp_ls = 0; exp_upd = 0;
   endtask

   // One clock edge of the reference: word acceptance/packing, then request servicing.
   task automatic model_edge(input bit v, input logic [WI-1:0] w, input bit l, input bit c, input bit r);
      bit     acc, pushed, had, served;
      entry_t pe, se;
      logic [WD-1:0] chunk;
      acc = v && (mq.size() < DEPTH);
      had = mq.size() > 0;
      pushed = 0;
      served = 0;
      pe = '0;
      se = '0;
      if (acc) begin
         if (!m_in_line) m_line_comp = c;
         wq.push_back(w);
         if (wq.size() == 4 || l) begin
            chunk = '0;
            foreach (wq[i]) chunk = chunk | (WD'(wq[i]) << (WI * i));
            pe = '{ls: m_first, cf: m_line_comp, d: chunk};
            pushed = 1;
            m_first = l;
            wq.delete();
         end
         m_in_line = !l;
      end
      if (m_pending && had) begin
         se = mq.pop_front();
         served = 1;
         m_pending = 0;
         if (r) m_overrun = 1;
      end else if (r && m_pending) begin
         m_overrun = 1;
      end else if (r) begin
         if (had) begin
            se = mq.pop_front();
            served = 1;
         end else if (pushed) begin
            se = pe;
            served = 1;
            pushed = 0;
         end else begin
            m_pending = 1;
         end
      end
      if (pushed) mq.push_back(pe);
      exp_upd = served;
      if (served) begin
         exp_data = se.d;
         exp_cf = se.cf;
         exp_ls = se.ls;
      end
   endtask

   // Starts and ends at a falling edge.
   task automatic step(input bit v, input logic [WI-1:0] w, input bit l, input bit c, input bit r);
      i_valid = v; i_word = w; i_last = l; i_comp_flag = c; i_req = r;
      #1;
      chk("o_ready", WD'(o_ready), WD'(mq.size() < DEPTH));
      @(posedge i_clk);
      model_edge(v, w, l, c, r);
      #1;
      chk("o_update", WD'(o_update), WD'(exp_upd));
      chk("o_data", o_data, exp_data);
      chk("o_comp_flag", WD'(o_comp_flag), WD'(exp_cf));
      chk("o_line_start", WD'(o_line_start), WD'(exp_ls));
      chk("o_overrun", WD'(o_overrun), WD'(m_overrun));
      @(negedge i_clk);
      i_valid = 0; i_req = 0; i_last = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
   endtask

   task automatic do_reset();
      i_reset = 0;
      i_valid = 1;
      #1;
      chk("rst_o_ready", WD'(o_ready), '0);
      chk("rst_o_data", o_data, '0);
      chk("rst_o_update", WD'(o_update), '0);
      chk("rst_o_comp_flag", WD'(o_comp_flag), '0);
      chk("rst_o_line_start", WD'(o_line_start), '0);
      chk("rst_o_overrun", WD'(o_overrun), '0);
      model_clear();
      @(negedge i_clk);
      @(negedge i_clk);
      i_valid = 0;
      i_reset = 1;
   endtask

   initial begin
      model_clear();
      @(negedge i_clk);
      do_reset();

      // 4-word compressed line, then one request
      step(1, 32'h11111111, 0, 1, 0);
      step(1, 32'h22222222, 0, 0, 0);
      step(1, 32'h33333333, 0, 0, 0);
      step(1, 32'h44444444, 1, 0, 0);
      i_req = 1;
      #1;
      @(posedge i_clk);
      model_edge(0, '0, 0, 0, 1);
      #1;
      chk("line4_data", o_data, 128'h44444444_33333333_22222222_11111111);
      chk("line4_update", WD'(o_update), WD'(1));
      chk("line4_comp", WD'(o_comp_flag), WD'(1));
      chk("line4_start", WD'(o_line_start), WD'(1));
      @(negedge i_clk);
      i_req = 0;
      idle(1);
      chk("hold_data", o_data, 128'h44444444_33333333_22222222_11111111);

      // 6-word uncompressed line -> two chunks
      for (int k = 0; k < 6; k++) step(1, 32'hA0000000 + 32'(k), k == 5, 0, 0);
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      chk("line6_upper", o_data[127:64], '0);
      chk("line6_start2", WD'(o_line_start), '0);

      // two full chunks without requests -> back-pressure until a pop
      for (int k = 0; k < 8; k++) step(1, 32'hB0000000 + 32'(k), k == 7, 1, 0);
      chk("full_ready", WD'(o_ready), '0);
      step(1, 32'hC0000000, 1, 0, 0);
      step(1, 32'hC0000000, 1, 0, 0);
      step(1, 32'hC0000000, 1, 0, 1);
      step(1, 32'hC0000000, 1, 0, 0);
      idle(1);
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      idle(1);

      // request on empty FIFO, second request while pending, words later
      step(0, '0, 0, 0, 1);
      idle(1);
      step(0, '0, 0, 0, 1);
      chk("overrun_set", WD'(o_overrun), WD'(1));
      idle(1);
      for (int k = 0; k < 4; k++) step(1, 32'hD0000000 + 32'(k), k == 3, 1, 0);
      step(0, '0, 0, 0, 0);
      chk("pend_update", WD'(o_update), WD'(1));
      idle(2);
      chk("overrun_sticky", WD'(o_overrun), WD'(1));

      // comp flag toggled mid-line is ignored
      do_reset();
      step(1, 32'hE0000000, 0, 1, 0);
      step(1, 32'hE0000001, 0, 0, 0);
      step(1, 32'hE0000002, 0, 1, 0);
      step(1, 32'hE0000003, 0, 0, 0);
      step(1, 32'hE0000004, 1, 0, 1);
      chk("toggle_comp1", WD'(o_comp_flag), WD'(1));
      step(0, '0, 0, 0, 1);
      chk("toggle_comp2", WD'(o_comp_flag), WD'(1));

      // push and request in the same cycle into an empty FIFO
      idle(1);
      step(1, 32'hF0000000, 1, 0, 1);
      chk("bypass_update", WD'(o_update), WD'(1));

      // reset mid-line discards the partial chunk
      step(1, 32'h99999999, 0, 1, 0);
      step(1, 32'h88888888, 0, 1, 0);
      do_reset();
      for (int k = 0; k < 4; k++) step(1, 32'h01010101 * 32'(k + 1), k == 3, 0, 0);
      step(0, '0, 0, 0, 1);
      chk("post_rst_data", o_data, 128'h04040404_03030303_02020202_01010101);
      chk("post_rst_start", WD'(o_line_start), WD'(1));

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if (n % 500 == 499) do_reset();
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
